// File: rtl/arb_mux_pkg.sv
// Shared constants and the rotating-priority search used by the arb_mux_rr block.
package arb_mux_pkg;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  // Largest input count the search function supports.
  localparam int unsigned MaxIn = 64;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } rr_result_t;

  // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... wrapping at n. Requires ptr < n.
  function automatic rr_result_t rr_first(input logic [MaxIn-1:0] valid,
                                          input int unsigned      ptr,
                                          input int unsigned      n);
    rr_result_t  res;
    logic [31:0] j;
    res = '0;
    for (int unsigned i = 0; i < MaxIn; i++) begin
      if (i < n) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (!res.found && valid[j]) begin
          res.found = 1'b1;
          res.idx   = j[5:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// rr_pick: combinational rotating-priority encoder (valid vector + pointer -> grant index).
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  in_valid,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [SEL_W-1:0] grant,
  output logic             found
);

  logic [MaxIn-1:0] valid_ext;
  rr_result_t       res;

  // Widen to the search width, scan from rr_ptr and narrow the index back down.
  always_comb begin
    valid_ext           = '0;
    valid_ext[N_IN-1:0] = in_valid;
    res                 = rr_first(valid_ext, 32'(rr_ptr), N_IN);
    grant               = res.idx[SEL_W-1:0];
    found               = res.found;
  end

endmodule

// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N_IN-way WIDTH-bit arbitrated mux with valid/ready handshakes and a
// single-entry registered output. Round-robin (mode=0) or fixed select (mode=1).
// Optional packet lock enabled by defining ARB_MUX_LOCK_EN (adds the in_last port).
module arb_mux_rr
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 8,
  parameter int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N_IN-1:0]       in_last,
`endif
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  input  logic                  out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_src_q;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] rr_grant, grant;
  logic             rr_found, has_grant, can_load, fire, advance;

`ifdef ARB_MUX_LOCK_EN
  typedef enum logic {StUnlocked, StLocked} lock_state_e;
  lock_state_e      state_q, state_d;
  logic [SEL_W-1:0] lock_src_q, lock_src_d;
`endif

  rr_pick #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .in_valid (in_valid),
    .rr_ptr   (rr_ptr_q),
    .grant    (rr_grant),
    .found    (rr_found)
  );

  // Choose the grant: an open packet lock wins, otherwise round-robin or fixed select.
  always_comb begin
    grant     = '0;
    has_grant = 1'b0;
`ifdef ARB_MUX_LOCK_EN
    if (state_q == StLocked) begin
      grant     = lock_src_q;
      has_grant = in_valid[lock_src_q];
    end else begin
`else
    begin
`endif
      if (mode == ARB_MODE_RR) begin
        grant     = rr_grant;
        has_grant = rr_found;
      end else if (32'(sel) < N_IN) begin
        grant     = sel;
        has_grant = in_valid[sel];
      end
    end
  end

  // Handshake: one-hot ready toward the granted input whenever the output slot can take a beat.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    fire     = can_load && has_grant && !reset;
    in_ready = '0;
    if (fire) in_ready[grant] = 1'b1;
    advance  = fire && (mode == ARB_MODE_RR);
`ifdef ARB_MUX_LOCK_EN
    // Pointer only moves when a packet closes.
    advance  = advance && in_last[grant];
`endif
    rr_ptr_d = (grant == SEL_W'(N_IN - 1)) ? '0 : grant + 1'b1;
  end

`ifdef ARB_MUX_LOCK_EN
  // Lock next-state: open on a non-last beat, close on the last beat of the locked source.
  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    case (state_q)
      StUnlocked: begin
        if (fire && !in_last[grant]) begin
          state_d    = StLocked;
          lock_src_d = grant;
        end
      end
      StLocked: begin
        if (fire && in_last[grant]) state_d = StUnlocked;
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StUnlocked;
      lock_src_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
    end
  end
`endif

  // Output register and round-robin pointer; a held beat stays put until drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      if (fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data[grant*WIDTH +: WIDTH];
        out_src_q   <= grant;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (advance) rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed bench for arb_mux_rr (N_IN=8, WIDTH=32). Also covers the lock option when
// ARB_MUX_LOCK_EN is defined.
module tb_arb_mux_rr;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N_IN  = 8;
  localparam int unsigned SEL_W = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_src;
  logic                  out_ready;
`ifdef ARB_MUX_LOCK_EN
  logic [N_IN-1:0]       in_last;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  arb_mux_rr #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic default_data();
    for (int i = 0; i < N_IN; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + 32'(i);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b0;
`ifdef ARB_MUX_LOCK_EN
    in_last   = '1;
`endif
    default_data();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", out_valid);
    else pass_cnt++;
    // Load input 4 and hold it.
    in_valid = 8'h10;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b1 || out_src !== 3'd4 || out_data !== 32'hA4)
      $display("FAIL reset_preload: valid=%b src=%0d data=%h want 1/4/a4",
               out_valid, out_src, out_data);
    else pass_cnt++;
    // Reset mid-transfer with everything requesting.
    reset    = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready !== 8'h00) $display("FAIL reset_ready: got %h want 00", in_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0 || out_src !== 3'd0 || out_data !== 32'h0)
      $display("FAIL reset_state: valid=%b src=%0d data=%h want 0/0/0",
               out_valid, out_src, out_data);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    // rr_ptr back at 0: with all valid, input 0 is granted.
    chk_cnt++;
    if (in_ready !== 8'h01) $display("FAIL reset_rr_ptr: in_ready=%h want 01", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_rr_sequence();
    do_reset();
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready !== 8'h01) $display("FAIL rr_first_ready: got %h want 01", in_ready);
    else pass_cnt++;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_cnt++;
      if (out_valid !== 1'b1 || out_src !== 3'(k % 8) || out_data !== 32'hA0 + 32'(k % 8))
        $display("FAIL rr_seq beat %0d: valid=%b src=%0d data=%h want 1/%0d/%h", k,
                 out_valid, out_src, out_data, k % 8, 32'hA0 + 32'(k % 8));
      else pass_cnt++;
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 8'h01;
    tick();
    chk_cnt++;
    if (out_src !== 3'd0) $display("FAIL wrap_setup: src=%0d want 0", out_src);
    else pass_cnt++;
    // rr_ptr is now 1: scan 1..7 finds 7 before wrapping to 0.
    in_valid = 8'h81;
    #1;
    chk_cnt++;
    if (in_ready !== 8'h80) $display("FAIL wrap_ready7: got %h want 80", in_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_src !== 3'd7 || out_data !== 32'hA7)
      $display("FAIL wrap_grant7: src=%0d data=%h want 7/a7", out_src, out_data);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_src !== 3'd0 || out_data !== 32'hA0)
      $display("FAIL wrap_grant0: src=%0d data=%h want 0/a0", out_src, out_data);
    else pass_cnt++;
    in_valid = 8'h00;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL wrap_drain: valid=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_fixed();
    do_reset();
    out_ready = 1'b1;
    mode      = 1'b1;
    sel       = 3'd3;
    in_valid  = 8'h08;
    in_data[3*WIDTH +: WIDTH] = 32'hDEADBEEF;
    #1;
    chk_cnt++;
    if (in_ready !== 8'h08) $display("FAIL fixed_ready: got %h want 08", in_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b1 || out_src !== 3'd3 || out_data !== 32'hDEADBEEF)
      $display("FAIL fixed_load: valid=%b src=%0d data=%h want 1/3/deadbeef",
               out_valid, out_src, out_data);
    else pass_cnt++;
    // Selected input idle: nothing else may win.
    in_valid = 8'hF7;
    #1;
    chk_cnt++;
    if (in_ready !== 8'h00) $display("FAIL fixed_nogrant: in_ready=%h want 00", in_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL fixed_drain: valid=%b want 0", out_valid);
    else pass_cnt++;
    // Fixed-mode transfers leave rr_ptr at 0.
    mode     = 1'b0;
    in_valid = 8'hFF;
    #1;
    chk_cnt++;
    if (in_ready !== 8'h01) $display("FAIL fixed_rr_hold: in_ready=%h want 01", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 8'h01;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b1 || out_src !== 3'd0)
      $display("FAIL bp_load: valid=%b src=%0d want 1/0", out_valid, out_src);
    else pass_cnt++;
    in_valid = 8'h04;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++;
      if (in_ready !== 8'h00) $display("FAIL bp_ready cycle %0d: got %h want 00", k, in_ready);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'hA0)
        $display("FAIL bp_hold cycle %0d: valid=%b src=%0d data=%h want 1/0/a0", k,
                 out_valid, out_src, out_data);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready !== 8'h04) $display("FAIL bp_release_ready: got %h want 04", in_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== 32'hA2)
      $display("FAIL bp_drain_load: valid=%b src=%0d data=%h want 1/2/a2",
               out_valid, out_src, out_data);
    else pass_cnt++;
    in_valid = 8'h00;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_final_drain: valid=%b want 0", out_valid);
    else pass_cnt++;
  endtask

`ifdef ARB_MUX_LOCK_EN
  task automatic test_lock();
    logic [SEL_W-1:0] exp_src [4];
    logic             last1 [4];
    exp_src = '{3'd1, 3'd1, 3'd1, 3'd2};
    last1   = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    out_ready = 1'b1;
    // Single-beat packet from 0 moves rr_ptr to 1.
    in_valid = 8'h01;
    tick();
    in_valid = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      in_last    = '1;
      in_last[1] = last1[k];
      tick();
      chk_cnt++;
      if (out_src !== exp_src[k])
        $display("FAIL lock beat %0d: src=%0d want %0d", k, out_src, exp_src[k]);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_sequence();
    test_rr_wrap();
    test_fixed();
    test_backpressure();
`ifdef ARB_MUX_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
